// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/subtract resolved one look-ahead group per pipeline stage with valid/ready flow control
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int L = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad
        $error("WIDTH must be a nonzero multiple of BLOCK");
    end

    function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] p, input logic [BLOCK-1:0] g, input logic ci);
        logic [BLOCK:0] cy;
        logic t;
        logic u;
        cy = '0;
        cy[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) t = t & p[j];
            for (int j = 0; j <= i; j++) begin
                u = g[j];
                for (int m = j + 1; m <= i; m++) u = u & p[m];
                t = t | u;
            end
            cy[i+1] = t;
        end
        return cy;
    endfunction

    assign in_ready = !out_valid || out_ready;

    for (genvar k = 0; k < L; k++) begin : g_stg
        localparam int LO = k * BLOCK;
        localparam int HI = LO + BLOCK;
        logic [WIDTH-LO-1:0] a_i;
        logic [WIDTH-LO-1:0] b_i;
        logic                c_i;
        logic                v_i;
        logic [BLOCK-1:0]    p;
        logic [BLOCK-1:0]    g;
        logic [BLOCK:0]      cy;
        logic [HI-1:0]       s_n;
        logic [HI-1:0]       s_r;
        logic                v_r;
        logic                c_r;
        if (k == 0) begin : g_src
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign c_i = sub | c_in;
            assign v_i = in_valid;
            assign s_n = p ^ cy[BLOCK-1:0];
        end else begin : g_src
            assign a_i = g_stg[k-1].g_fwd.a_r;
            assign b_i = g_stg[k-1].g_fwd.b_r;
            assign c_i = g_stg[k-1].c_r;
            assign v_i = g_stg[k-1].v_r;
            assign s_n = {p ^ cy[BLOCK-1:0], g_stg[k-1].s_r};
        end
        assign p  = a_i[BLOCK-1:0] ^ b_i[BLOCK-1:0];
        assign g  = a_i[BLOCK-1:0] & b_i[BLOCK-1:0];
        assign cy = cla(p, g, c_i);
        // advance valid on every unstalled cycle; data only moves with a real transaction so bubbles keep the last result
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (in_ready) begin
                v_r <= v_i;
                if (v_i) begin
                    c_r <= cy[BLOCK];
                    s_r <= s_n;
                end
            end
        end
        if (k < L - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] a_r;
            logic [WIDTH-HI-1:0] b_r;
            // carry the not-yet-resolved upper operand bits forward with the transaction
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (in_ready && v_i) begin
                    a_r <= a_i[WIDTH-LO-1:BLOCK];
                    b_r <= b_i[WIDTH-LO-1:BLOCK];
                end
            end
        end else begin : g_last
            logic m_r;
            logic z_r;
            // capture the carry into the MSB and the zero test alongside the final sum slice
            always_ff @(posedge clk) begin
                if (rst) begin
                    m_r <= 1'b0;
                    z_r <= 1'b0;
                end else if (in_ready && v_i) begin
                    m_r <= cy[BLOCK-1];
                    z_r <= (s_n == '0);
                end
            end
        end
    end

    assign out_valid = g_stg[L-1].v_r;
    assign s         = g_stg[L-1].s_r;
    assign c_out     = g_stg[L-1].c_r;
    assign ovf       = g_stg[L-1].g_last.m_r ^ g_stg[L-1].c_r;
    assign zero      = g_stg[L-1].g_last.z_r;
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry look-ahead adder.
- Splits a WIDTH-bit add/subtract into WIDTH/BLOCK look-ahead groups.
- Each group is resolved in its own register stage, and the group carry is passed between stages.
- Sits between operand-producing logic and ALU/result consumers, and provides valid/ready flow control with back-pressure.

Parameters:
- WIDTH, default 16: operand and result width in bits. Must be a multiple of BLOCK, and WIDTH >= BLOCK.
- BLOCK, default 4: bits per look-ahead group, i.e. bits resolved per pipeline stage.
- L is derived, not overridable: L = WIDTH/BLOCK, the number of pipeline stages.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand set present.
- in_ready, output, 1: block can accept operands this cycle.
- a, input, WIDTH: operand A (two's complement for flags).
- b, input, WIDTH: operand B.
- c_in, input, 1: carry-in. Used only in add mode.
- sub, input, 1: 0 = A + B + c_in; 1 = A - B.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result this cycle.
- s, output, WIDTH: sum/difference.
- c_out, output, 1: carry-out of the MSB. In subtract mode this means no-borrow.
- ovf, output, 1: signed overflow.
- zero, output, 1: s == 0.

Behaviour:
- Reset: on a rising edge with rst = 1, all stage valid bits clear. s, c_out, ovf, zero and out_valid all go to 0. in_ready is 1 in the cycle after reset. rst overrides any handshake in the same cycle, and in-flight operations are discarded with no output.
- Operation select: when sub = 1, the effective B is ~b and the effective carry-in is 1, and c_in is ignored. When sub = 0, the effective B is b and the effective carry-in is c_in. sub is captured with the operands.
- Group arithmetic: within each group, P = a ^ b_eff and G = a & b_eff. Group carries are formed by full look-ahead expressions, not ripple. Each sum bit is P ^ carry.
- Pipeline: stage k (0..L-1) computes group k from its registered operand slice and the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Not-yet-processed upper operand slices travel forward (skewed) with the transaction.
  - Completed lower sum slices travel forward (deskewed).
- Latency: operands accepted on edge n (in_valid && in_ready) appear on the outputs with out_valid = 1 immediately after edge n+L-1, i.e. L edges counting the accept edge. For L = 1 the result is visible right after the accept edge.
- Throughput: one result per cycle when out_ready is held high.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - When out_valid && !out_ready, every stage, including valid bits, holds its contents. s and the flags stay stable, and no input is accepted.
  - Bubbles are not collapsed.
  - in_valid = 0 on an accept-eligible cycle inserts a bubble, with stage-0 valid = 0.
  - A simultaneous output pop and input accept in the same cycle is legal and loses nothing.
- Flags:
  - c_out is the carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR c_out.
  - zero = (s == 0), registered with the final stage.
  - All flags are meaningful only while out_valid = 1. They hold their last values when out_valid = 0.
- Wrap-around: results are modulo 2^WIDTH. No saturation.
- Inputs are don't-care when in_valid = 0 or in_ready = 0. The block never samples them then.

Test Plan (WIDTH = 16, BLOCK = 4, L = 4 unless noted):
- Reset and latency: assert rst for 2 cycles, then send a = 16'h1234, b = 16'h4321, c_in = 0, sub = 0 once, with out_ready = 1.
  - Required: outputs stay 0 with out_valid = 0 until edge n+3.
  - Then s = 16'h5555, c_out = 0, ovf = 0, zero = 0, with out_valid high for exactly 1 cycle.
- Full carry chain: send a = 16'hFFFF, b = 16'h0000, c_in = 1.
  - Required: s = 16'h0000, c_out = 1, zero = 1, ovf = 0.
  - This shows the carry crossing all 4 stages.
- Subtract and overflow:
  - 16'h8000 - 16'h0001 -> s = 16'h7FFF, c_out = 1, ovf = 1.
  - 16'h0003 - 16'h0005 -> s = 16'hFFFE, c_out = 0, ovf = 0.
  - 16'h7FFF + 16'h0001 -> s = 16'h8000, ovf = 1.
- Back-pressure: stream 8 back-to-back random add/sub transactions, with out_ready low on cycles 5-7 after the first result.
  - Required: in_ready low exactly while out_valid && !out_ready.
  - s held stable during the stall.
  - All 8 results emitted in order and matching a golden model, with no drops or duplicates.
- Reset mid-operation: accept 3 transactions, then assert rst one cycle later.
  - Required: out_valid = 0 and outputs 0 after the reset edge.
  - None of the 3 results ever appear.
  - A new transaction sent after reset completes with latency 4.
- Parameter sweep: WIDTH = 4 / BLOCK = 4 (L = 1) and WIDTH = 32 / BLOCK = 8 (L = 4), each with 1000 random back-to-back operations under random out_ready.
  - Required: all s/c_out/ovf/zero values match the golden model.
  - Latency is L in both configurations.
